branch_predict_ctrl: RTL

//  Direct-mapped branch predictor plus flush/redirect controller for the 5-stage pipeline.

---
 rtl/branch_predict_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped 2-bit BHT + tagged BTB predictor with MEM-stage resolve,
// mispredict flush/redirect generation and saturating branch statistics.
module branch_predict_ctrl #(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 26,
  parameter int STAT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       f_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              r_valid,
  input  logic              r_stall,
  input  logic              r_branch,
  input  logic              r_bne,
  input  logic              r_zero,
  input  logic [31:0]       r_pc,
  input  logic [31:0]       r_target,
  input  logic              r_pred_taken,
  input  logic [31:0]       r_pred_target,
  output logic              flushFD,
  output logic              flushDE,
  output logic              flushEM,
  output logic              redirect_en,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int N = 1 << IDX_BITS;

  logic [1:0]          bht     [N];
  logic                btb_v   [N];
  logic [TAG_BITS-1:0] btb_tag [N];
  logic [31:0]         btb_tgt [N];

  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0] f_tag;
  logic [IDX_BITS-1:0] r_idx;
  logic [TAG_BITS-1:0] r_tag;
  logic                hit;
  logic                ev;
  logic                act;
  logic                mis;
  logic [31:0]         act_pc;
  logic                unused_bits;

  assign f_idx = f_pc[IDX_BITS+1:2];
  assign f_tag = f_pc[31:IDX_BITS+2];
  assign r_idx = r_pc[IDX_BITS+1:2];
  assign r_tag = r_pc[31:IDX_BITS+2];
  assign unused_bits = ^{f_pc[1:0], r_pc[1:0]};

  // Lookup reads the pre-edge tables; a same-cycle training write is not forwarded.
  assign hit         = btb_v[f_idx] && (btb_tag[f_idx] == f_tag);
  assign pred_taken  = hit && bht[f_idx][1];
  assign pred_target = pred_taken ? btb_tgt[f_idx] : f_pc + 32'd4;

  assign ev     = r_valid && r_branch && !r_stall && !RST;
  assign act    = r_bne ? !r_zero : r_zero;
  assign act_pc = act ? r_target : r_pc + 32'd4;
  assign mis    = ev && ((act != r_pred_taken) || (act && (r_pred_target != r_target)));

  assign flushFD     = mis;
  assign flushDE     = mis;
  assign flushEM     = mis;
  assign redirect_en = mis;
  assign redirect_pc = mis ? act_pc : 32'd0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        bht[i]     <= 2'b01;
        btb_v[i]   <= 1'b0;
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
      end
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (ev) begin
        if (act) begin
          if (bht[r_idx] != 2'b11) bht[r_idx] <= bht[r_idx] + 2'd1;
          btb_v[r_idx]   <= 1'b1;
          btb_tag[r_idx] <= r_tag;
          btb_tgt[r_idx] <= r_target;
        end else if (bht[r_idx] != 2'b00) begin
          bht[r_idx] <= bht[r_idx] - 2'd1;
        end
        if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
      end
      if (mis && (stat_mispred != '1)) stat_mispred <= stat_mispred + 1'b1;
    end
  end

endmodule
